decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does: clk (clock) and rst (reset).
REQ-002 clk  input  1  Clock; all state updates on the rising edge.
REQ-003 rst  input  1  Asynchronous, active-high reset; clears all registered outputs immediately when asserted.
REQ-004 a  input  4  Operand A, unsigned.
REQ-005 b  input  4  Operand B, unsigned.
REQ-006 s  input  2  Operation select: 00 add, 01 subtract, 10 compare, 11 bitwise AND.
REQ-007 y0  output  4  Sum result; registered.
REQ-008 y1  output  4  Subtraction magnitude; registered.
REQ-009 y2  output  4  Compare flags {1'b0, ga, gb, e}; registered.
REQ-010 y3  output  4  Bitwise AND result; registered.
REQ-011 cout  output  1  Carry out of the addition; registered.
REQ-012 sign  output  1  Subtraction sign (1 = negative); registered.

Function
REQ-013 The block SHALL sample a, b and s on every rising clk edge and SHALL update all outputs on that edge, giving a latency of one cycle.
REQ-014 There SHALL be no handshake; every clock edge is a new operation, and back-to-back operations SHALL be supported at full rate.
REQ-015 Only the output selected by s SHALL carry a result; the other three y outputs SHALL be registered as 4'b0000 in the same cycle.
REQ-016 s=00: {cout, y0} = a + b as a 5-bit unsigned sum; sign = 0.
REQ-017 s=01: sign = 1 when a < b, else 0; y1 = |a − b| (a−b when a≥b, b−a when a<b), always 4 bits, no wrap; cout = 0.
REQ-018 s=10: y2[3] = 0; y2[2] = ga = (a > b); y2[1] = gb = (a < b); y2[0] = e = (a == b); exactly one of ga/gb/e SHALL be 1; cout = sign = 0.
REQ-019 s=11: y3 = a & b bitwise; cout = sign = 0.
REQ-020 Boundaries: 15+15 -> y0=1110, cout=1; 0+0 -> y0=0000, cout=0; a==b under s=01 -> y1=0000, sign=0; 0−15 -> y1=1111, sign=1.
REQ-021 A change of s between edges SHALL have no effect on outputs until the next rising edge; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-022 While rst=1, y0..y3 SHALL be 4'b0000 and cout = sign = 0, regardless of clk, a, b and s.
REQ-023 Asserting rst mid-operation SHALL clear the outputs immediately, without waiting for a clock edge; the in-flight result is discarded.
REQ-024 After rst deasserts, the first rising clk edge SHALL register a valid result for the a, b and s present at that edge.

Verification
REQ-025 a=0111, b=1110, s=00 -> next edge: y0=0101, cout=1, sign=0, y1=y2=y3=0000.
REQ-026 a=0111, b=1110, s=01 -> y1=0111, sign=1, cout=0, others 0000.
REQ-027 a=0111, b=1110, s=10 -> y2=0010 (gb=1); a=b=1001, s=10 -> y2=0001; a=1110, b=0111 -> y2=0100.
REQ-028 a=0111, b=1110, s=11 -> y3=0110, cout=sign=0, others 0000.
REQ-029 Boundaries: s=00 with a=b=1111 -> y0=1110, cout=1; s=01 with a=0000, b=1111 -> y1=1111, sign=1.
REQ-030 Reset: assert rst between edges while y0=0101 and cout=1 -> all outputs 0 before the next edge; deassert rst -> the next edge restores the correct result.

Source files
------------

// File: rtl/decoder.sv
// ============================================================================
// Module   : decoder
// Brief    : Registered 4-bit ALU slice (add/sub/compare/AND), one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] s,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic       cout,
  output logic       sign
);

  localparam logic [1:0] C_OP_ADD = 2'b00;
  localparam logic [1:0] C_OP_SUB = 2'b01;
  localparam logic [1:0] C_OP_CMP = 2'b10;
  localparam logic [1:0] C_OP_AND = 2'b11;

  logic [4:0] w_sum;
  logic [3:0] w_mag;
  logic       w_lt;
  logic       w_gt;
  logic       w_eq;

  logic [3:0] w_y0;
  logic [3:0] w_y1;
  logic [3:0] w_y2;
  logic [3:0] w_y3;
  logic       w_cout;
  logic       w_sign;

  logic [3:0] r_y0;
  logic [3:0] r_y1;
  logic [3:0] r_y2;
  logic [3:0] r_y3;
  logic       r_cout;
  logic       r_sign;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_lt  = (a < b);
  assign w_gt  = (a > b);
  assign w_eq  = (a == b);
  // Subtract in the direction that keeps the result non-negative.
  assign w_mag = w_lt ? (b - a) : (a - b);

  always_comb begin
    w_y0   = 4'b0000;
    w_y1   = 4'b0000;
    w_y2   = 4'b0000;
    w_y3   = 4'b0000;
    w_cout = 1'b0;
    w_sign = 1'b0;
    case (s)
      C_OP_ADD: begin
        w_y0   = w_sum[3:0];
        w_cout = w_sum[4];
      end
      C_OP_SUB: begin
        w_y1   = w_mag;
        w_sign = w_lt;
      end
      C_OP_CMP: w_y2 = {1'b0, w_gt, w_lt, w_eq};
      C_OP_AND: w_y3 = a & b;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y0   <= 4'b0000;
      r_y1   <= 4'b0000;
      r_y2   <= 4'b0000;
      r_y3   <= 4'b0000;
      r_cout <= 1'b0;
      r_sign <= 1'b0;
    end else begin
      r_y0   <= w_y0;
      r_y1   <= w_y1;
      r_y2   <= w_y2;
      r_y3   <= w_y3;
      r_cout <= w_cout;
      r_sign <= w_sign;
    end
  end

  assign y0   = r_y0;
  assign y1   = r_y1;
  assign y2   = r_y2;
  assign y3   = r_y3;
  assign cout = r_cout;
  assign sign = r_sign;

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
// ============================================================================
// Module   : tb_decoder
// Brief    : Directed vector bench for decoder, plus reset and input-change sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] s;
  logic [3:0] y0;
  logic [3:0] y1;
  logic [3:0] y2;
  logic [3:0] y3;
  logic       cout;
  logic       sign;

  int compared;
  int mismatched;

  decoder dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .s    (s),
    .y0   (y0),
    .y1   (y1),
    .y2   (y2),
    .y3   (y3),
    .cout (cout),
    .sign (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output order: {y0, y1, y2, y3, cout, sign}
  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [1:0]  s;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [17:0] pack(input logic [3:0] p0, input logic [3:0] p1,
                                       input logic [3:0] p2, input logic [3:0] p3,
                                       input logic pc, input logic ps);
    return {p0, p1, p2, p3, pc, ps};
  endfunction

  task automatic check(input string name, input logic [17:0] expv);
    logic [17:0] act;
    act = {y0, y1, y2, y3, cout, sign};
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got y0=%b y1=%b y2=%b y3=%b cout=%b sign=%b, want y0=%b y1=%b y2=%b y3=%b cout=%b sign=%b",
               name, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               expv[17:14], expv[13:10], expv[9:6], expv[5:2], expv[1], expv[0]);
    end
  endtask

  task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic [1:0] vs);
    @(negedge clk);
    a = va;
    b = vb;
    s = vs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{4'd7,  4'd14, 2'b00, pack(4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0)};
    vecs[1]  = '{4'd7,  4'd14, 2'b01, pack(4'b0000, 4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b1)};
    vecs[2]  = '{4'd7,  4'd14, 2'b10, pack(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0)};
    vecs[3]  = '{4'd9,  4'd9,  2'b10, pack(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0)};
    vecs[4]  = '{4'd14, 4'd7,  2'b10, pack(4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0)};
    vecs[5]  = '{4'd7,  4'd14, 2'b11, pack(4'b0000, 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b0)};
    vecs[6]  = '{4'd15, 4'd15, 2'b00, pack(4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0)};
    vecs[7]  = '{4'd0,  4'd0,  2'b00, pack(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0)};
    vecs[8]  = '{4'd9,  4'd9,  2'b01, pack(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0)};
    vecs[9]  = '{4'd0,  4'd15, 2'b01, pack(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1)};
    vecs[10] = '{4'd14, 4'd7,  2'b01, pack(4'b0000, 4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b0)};
    vecs[11] = '{4'd12, 4'd10, 2'b11, pack(4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0)};
    vecs[12] = '{4'd3,  4'd4,  2'b00, pack(4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0)};

    // Reset state, held across a clock edge with non-zero inputs
    rst = 1'b1;
    a   = 4'd15;
    b   = 4'd15;
    s   = 2'b00;
    #1;
    check("reset_initial", 18'd0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 18'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table vectors
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Input change between edges must not reach outputs
    apply(4'd7, 4'd14, 2'b00);
    #2;
    s = 2'b11;
    a = 4'd1;
    #1;
    check("no_comb_path", vecs[0].exp);
    @(posedge clk);
    #1;
    check("after_change_edge", pack(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));

    // Asynchronous reset mid-cycle, then recovery on the first edge
    apply(4'd7, 4'd14, 2'b00);
    check("pre_reset", vecs[0].exp);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_clear", 18'd0);
    @(negedge clk);
    rst = 1'b0;
    check("reset_release_before_edge", 18'd0);
    @(posedge clk);
    #1;
    check("post_reset_restore", vecs[0].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
